instr_fetch_unit: RTL and testbench

- Sequential consumer of the 256x8 synchronous-read program ROM (read data appears one clock after the address is sampled).
- Owns the fetch program counter and drives the ROM address.
- Absorbs the one-cycle ROM latency with a 2-entry instruction buffer.
- Hands instruction bytes, each tagged with its address, to the processor decode stage over a valid/ready handshake; supports jump redirect and halt.

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch program counter, ROM address driver and 2-entry
// instruction buffer feeding the decode stage over a valid/ready handshake.
// Latency: issue at edge n, entry valid after edge n+1 (two edges after reset
// release / jump). Backpressure: holds the head and stops issuing ROM reads
// once buffered + in-flight entries reach two; HALT also stops issuing.
//
// Ports:
//   CLK, RESET                 clock, async active-high reset
//   ROM_ADDR / ROM_DATA        ROM address (straight from fetch_pc) / read data one cycle later
//   INSTR_DATA/ADDR/VALID      buffer head toward decode; INSTR_READY accepts it
//   JUMP_EN / JUMP_ADDR        redirect fetch, flushing buffer and in-flight read
//   HALT                       suppress new ROM reads; buffer keeps draining
//   STALL_COUNT                present only when IFU_STALL_COUNT_EN is defined:
//                              saturating count of cycles with no valid head and no HALT
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    output logic [ADDR_WIDTH-1:0] ROM_ADDR,
    input  logic [DATA_WIDTH-1:0] ROM_DATA,
    output logic [DATA_WIDTH-1:0] INSTR_DATA,
    output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
    output logic                  INSTR_VALID,
    input  logic                  INSTR_READY,
    input  logic                  JUMP_EN,
    input  logic [ADDR_WIDTH-1:0] JUMP_ADDR,
    input  logic                  HALT
`ifdef IFU_STALL_COUNT_EN
    ,
    output logic [15:0]           STALL_COUNT
`endif
);

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
    logic [1:0]            count_q, count_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] fifo_addr_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_q [2];

    logic       pop;
    logic       issue;
    logic       capture;
    logic [1:0] occupancy;

    assign ROM_ADDR    = fetch_pc_q;
    assign INSTR_VALID = (count_q != 2'd0);
    assign INSTR_ADDR  = fifo_addr_q[rd_ptr_q];
    assign INSTR_DATA  = fifo_data_q[rd_ptr_q];

    always_comb begin
        pop       = INSTR_VALID & INSTR_READY;
        // Buffered entries plus the read still in flight: every slot that a
        // future capture could need. Never exceeds 2, so 2 bits suffice.
        occupancy = count_q + {1'b0, inflight_q};
        // A full pipeline may still issue when the head leaves this edge,
        // which is what sustains one instruction per cycle.
        issue     = !HALT && !JUMP_EN &&
                    ((occupancy < 2'd2) || ((occupancy == 2'd2) && pop));
        capture   = inflight_q && !JUMP_EN;

        fetch_pc_d      = fetch_pc_q;
        inflight_d      = inflight_q;
        inflight_addr_d = inflight_addr_q;
        count_d         = count_q;
        rd_ptr_d        = rd_ptr_q;
        wr_ptr_d        = wr_ptr_q;

        if (JUMP_EN) begin
            // Redirect wins: flush buffer, squash the read returning now.
            // A head transferred on this edge is simply discarded with the rest.
            fetch_pc_d = JUMP_ADDR;
            inflight_d = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = wr_ptr_q;
        end else begin
            inflight_d = issue;
            if (issue) begin
                inflight_addr_d = fetch_pc_q;
                fetch_pc_d      = fetch_pc_q + 1'b1;
            end
            if (pop)     rd_ptr_d = ~rd_ptr_q;
            if (capture) wr_ptr_d = ~wr_ptr_q;
            count_d = count_q + {1'b0, capture} - {1'b0, pop};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_pc_q      <= RESET_VECTOR;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            count_q         <= 2'd0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            if (capture) begin
                fifo_addr_q[wr_ptr_q] <= inflight_addr_q;
                fifo_data_q[wr_ptr_q] <= ROM_DATA;
            end
        end
    end

`ifdef IFU_STALL_COUNT_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_count_q <= 16'd0;
        end else if (!INSTR_VALID && !HALT && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign STALL_COUNT = stall_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a ROM model ROM[a] = a ^ 8'h5A.
// Inputs change and outputs are sampled on the falling clock edge.
// Covers reset, streaming, backpressure, jumps, wrap, halt and mid-stream reset.
module tb_instr_fetch_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] ROM_ADDR;
    logic [7:0] ROM_DATA;
    logic [7:0] INSTR_DATA;
    logic [7:0] INSTR_ADDR;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic       JUMP_EN;
    logic [7:0] JUMP_ADDR;
    logic       HALT;
`ifdef IFU_STALL_COUNT_EN
    logic [15:0] STALL_COUNT;
`endif

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_unit #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (8),
        .RESET_VECTOR(8'h00)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .INSTR_DATA (INSTR_DATA),
        .INSTR_ADDR (INSTR_ADDR),
        .INSTR_VALID(INSTR_VALID),
        .INSTR_READY(INSTR_READY),
        .JUMP_EN    (JUMP_EN),
        .JUMP_ADDR  (JUMP_ADDR),
        .HALT       (HALT)
`ifdef IFU_STALL_COUNT_EN
        ,
        .STALL_COUNT(STALL_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Synchronous-read ROM: data for the address sampled at an edge appears after it.
    always @(posedge CLK) ROM_DATA <= ROM_ADDR ^ 8'h5A;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [7:0] a);
        chk({tag, "_valid"}, {15'd0, INSTR_VALID}, 16'd1);
        chk({tag, "_addr"},  {8'd0, INSTR_ADDR},   {8'd0, a});
        chk({tag, "_data"},  {8'd0, INSTR_DATA},   {8'd0, a ^ 8'h5A});
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {15'd0, INSTR_VALID}, 16'd0);
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RESET       = 1'b1;
        INSTR_READY = 1'b1;
        JUMP_EN     = 1'b0;
        JUMP_ADDR   = 8'h00;
        HALT        = 1'b0;
        ROM_DATA    = 8'h00;

        // Reset state.
        #1;
        chk("rst_valid",    {15'd0, INSTR_VALID}, 16'd0);
        chk("rst_rom_addr", {8'd0, ROM_ADDR},     16'h0000);
        chk("rst_data",     {8'd0, INSTR_DATA},   16'h0000);
        chk("rst_addr",     {8'd0, INSTR_ADDR},   16'h0000);

        // Release: first edge issues 00, valid after the second edge, then gapless stream.
        @(negedge CLK);
        RESET = 1'b0;
        step();
        chk_empty("start_e1");
        chk("start_e1_rom_addr", {8'd0, ROM_ADDR}, 16'h0001);
        step(); chk_head("s00", 8'h00);
        step(); chk_head("s01", 8'h01);
        step(); chk_head("s02", 8'h02);
        step(); chk_head("s03", 8'h03);
`ifdef IFU_STALL_COUNT_EN
        chk("stall_after_start", STALL_COUNT, 16'd2);
`endif

        // HALT for 5 cycles: only the in-flight entry (04) is still delivered.
        HALT = 1'b1;
        step(); chk_head("halt_04", 8'h04);
        step(); chk_empty("halt_drained");
        step();
        step();
        step(); chk_empty("halt_still_empty");
        chk("halt_rom_addr", {8'd0, ROM_ADDR}, 16'h0005);
`ifdef IFU_STALL_COUNT_EN
        chk("stall_during_halt", STALL_COUNT, 16'd2);
`endif
        HALT = 1'b0;
        step(); chk_empty("resume_bubble");
        step(); chk_head("resume_05", 8'h05);
        step(); chk_head("resume_06", 8'h06);
`ifdef IFU_STALL_COUNT_EN
        chk("stall_after_resume", STALL_COUNT, 16'd4);
`endif

        // Asynchronous reset mid-stream, asserted between edges.
        RESET = 1'b1;
        #1;
        chk("mid_rst_valid",    {15'd0, INSTR_VALID}, 16'd0);
        chk("mid_rst_rom_addr", {8'd0, ROM_ADDR},     16'h0000);
        @(negedge CLK);
        RESET = 1'b0;
        step(); chk_empty("restart_e1");
        step(); chk_head("restart_00", 8'h00);

        // Backpressure for 10 cycles: head holds, ROM_ADDR parks at 02.
        INSTR_READY = 1'b0;
        step();
        chk("bp_rom_addr_first", {8'd0, ROM_ADDR}, 16'h0002);
        for (int i = 0; i < 9; i++) step();
        chk_head("bp_hold", 8'h00);
        chk("bp_rom_addr", {8'd0, ROM_ADDR}, 16'h0002);
        INSTR_READY = 1'b1;
        step(); chk_head("bp_rel_01", 8'h01);
        step(); chk_head("bp_rel_02", 8'h02);
        step(); chk_head("bp_rel_03", 8'h03);
        step(); chk_head("bp_rel_04", 8'h04);

        // Jump to 40 while streaming: two empty cycles, no stale bytes.
        JUMP_EN   = 1'b1;
        JUMP_ADDR = 8'h40;
        step();
        JUMP_EN = 1'b0;
        chk_empty("jmp40_b1");
        chk("jmp40_rom_addr", {8'd0, ROM_ADDR}, 16'h0040);
        step(); chk_empty("jmp40_b2");
        step(); chk_head("jmp40_40", 8'h40);
        step(); chk_head("jmp40_41", 8'h41);

        // Back-to-back jumps: the last target wins.
        JUMP_EN   = 1'b1;
        JUMP_ADDR = 8'h10;
        step();
        JUMP_ADDR = 8'h20;
        step();
        JUMP_EN = 1'b0;
        chk_empty("jmp2_b1");
        step(); chk_empty("jmp2_b2");
        step(); chk_head("jmp2_20", 8'h20);

        // Address wrap FF -> 00.
        JUMP_EN   = 1'b1;
        JUMP_ADDR = 8'hFC;
        step();
        JUMP_EN = 1'b0;
        step();
        step(); chk_head("wrap_fc", 8'hFC);
        step(); chk_head("wrap_fd", 8'hFD);
        step(); chk_head("wrap_fe", 8'hFE);
        step(); chk_head("wrap_ff", 8'hFF);
        step(); chk_head("wrap_00", 8'h00);
        step(); chk_head("wrap_01", 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
